sbox_sequencer: RTL
===================

Name: sbox_sequencer

Overview:
- Time-multiplexes one shared 6-to-4 S-box lookup unit across all eight DES S-box slices of a round.
- Accepts a 48-bit post-expansion/key-XOR word and presents one 6-bit chunk per cycle with its S-box index. It collects the 4-bit results into a 32-bit word for the P-permutation stage.
- Sits between the round-key XOR and the permutation in the Triple DES core. This lets the core share a single S-box bank instead of instantiating eight parallel copies.

Parameters:
- NUM_BOX, 8, number of S-box slices per round; fixed to 8 for DES.
- IN_W, 6, bits per S-box input chunk.
- OUT_W, 4, bits per S-box output nibble.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- in_valid  input  1  requester has a 48-bit word on data_in
- in_ready  output  1  sequencer can accept a word
- data_in  input  48  round input; chunk k = data_in[47-6k -: 6]
- abort  input  1  synchronous cancel of the current job
- sbox_sel  output  3  S-box index 0..7 (0 = S1) to the shared bank
- sbox_in  output  6  chunk to the shared bank (raw bits; bank does row/column split)
- sbox_out  input  4  combinational bank result for sbox_sel/sbox_in
- out_valid  output  1  data_out holds a completed 32-bit result
- out_ready  input  1  consumer takes the result
- data_out  output  32  assembled result; nibble k = data_out[31-4k -: 4]
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (n_rst low, async): state=IDLE, idx=0, input register=0, data_out=0, out_valid=0, in_ready=1, busy=0, sbox_sel=0, sbox_in=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture data_in, clear idx, go to RUN.
  - RUN: in_ready=0. Each cycle drive sbox_sel=idx and sbox_in=chunk idx of the captured word. At the clock edge, write sbox_out into nibble idx of data_out. If idx==7, go to DONE; otherwise idx+1.
  - DONE: out_valid=1, data_out stable. On out_ready, go to IDLE with out_valid=0 in the next cycle.
- Latency:
  - Accept edge T; lookups occupy cycles T+1..T+8; out_valid is first visible in the cycle after edge T+8.
  - Minimum 8 cycles from accept to out_valid; minimum 10 cycles accept-to-accept.
  - No back-to-back accept while in DONE.
- sbox_sel/sbox_in are driven to 0 outside RUN. The bank output is ignored outside RUN.
- data_out is written only in RUN. It holds the last result through IDLE until the next job's first lookup edge.
- abort:
  - Honoured in any state; return to IDLE next cycle, idx=0, out_valid=0.
  - data_out is not cleared; partial nibbles may remain.
  - abort in DONE discards the pending result.
  - abort has priority over out_ready and over a same-cycle accept in IDLE, so no job starts.
- in_valid while not in_ready is ignored; the requester must hold data_in until accepted.
- out_ready while out_valid=0 has no effect.
- n_rst asserted mid-RUN or in DONE: immediate return to reset values; no output is produced.
- idx is 3 bits and never wraps inside RUN; the transition at 7 is explicit.

Decomposition:
- Shared package des_pkg holds:
  - typedef sbox_idx_t (3-bit) and typedef for the sequencer state enum {IDLE, RUN, DONE};
  - constants NUM_BOX=8, SBOX_IN_W=6, SBOX_OUT_W=4, ROUND_IN_W=48, ROUND_OUT_W=32.
- Sub-module sbox_bank is a combinational 8-way select of S1..S8 driven by sbox_sel. It lives outside the sequencer, in the round datapath and in the bench.
- Sequencer RTL stays a single module.

Test Plan:
- Reset, then data_in=48'h0 with in_valid, out_ready=1 -> out_valid after 8 lookup cycles, data_out=32'hEFA72C4D; sbox_sel steps 0..7 on consecutive cycles.
- data_in=48'hFFFF_FFFF_FFFF -> data_out=32'hD9CE3DCB; sbox_in=6'h3F for all 8 lookups.
- out_ready held low 5 cycles after completion -> out_valid and data_out stable, in_ready=0 throughout; out_ready high -> IDLE and in_ready=1 next cycle.
- abort asserted at the 4th lookup cycle -> IDLE next cycle; out_valid never rises; next job with data_in=0 still yields 32'hEFA72C4D.
- n_rst pulsed low mid-RUN (3rd lookup) -> all outputs immediately at reset values (data_out=0); a new job after release completes correctly.
- in_valid held high with out_ready=1 continuously -> accepts spaced exactly 10 cycles apart; no accept while busy=1.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES round types, widths and S-box sequencing helpers
package des_pkg;

    localparam int NUM_BOX     = 8;
    localparam int SBOX_IN_W   = 6;
    localparam int SBOX_OUT_W  = 4;
    localparam int ROUND_IN_W  = 48;
    localparam int ROUND_OUT_W = 32;

    typedef logic [2:0] sbox_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam sbox_idx_t LAST_IDX = sbox_idx_t'(NUM_BOX - 1);

    // Chunk k of the round word, with chunk 0 (for S1) in the top six bits.
    function automatic logic [SBOX_IN_W-1:0] get_chunk(input logic [ROUND_IN_W-1:0] w,
                                                       input sbox_idx_t k);
        int sh;
        sh = (ROUND_IN_W - SBOX_IN_W) - SBOX_IN_W * int'(k);
        return SBOX_IN_W'(w >> sh);
    endfunction

    // Replace nibble k of the result word, with nibble 0 (from S1) in the top four bits.
    function automatic logic [ROUND_OUT_W-1:0] set_nibble(input logic [ROUND_OUT_W-1:0] w,
                                                          input sbox_idx_t k,
                                                          input logic [SBOX_OUT_W-1:0] n);
        int sh;
        logic [ROUND_OUT_W-1:0] mask;
        logic [ROUND_OUT_W-1:0] ins;
        sh   = (ROUND_OUT_W - SBOX_OUT_W) - SBOX_OUT_W * int'(k);
        mask = {{(ROUND_OUT_W-SBOX_OUT_W){1'b0}}, {SBOX_OUT_W{1'b1}}} << sh;
        ins  = {{(ROUND_OUT_W-SBOX_OUT_W){1'b0}}, n} << sh;
        return (w & ~mask) | ins;
    endfunction

endpackage

// File: rtl/sbox_sequencer_if.sv
// rtl/sbox_sequencer_if.sv - requester, result and shared S-box bank signals of the sequencer
interface sbox_sequencer_if;

    logic                             in_valid;
    logic                             in_ready;
    logic [des_pkg::ROUND_IN_W-1:0]   data_in;
    logic                             abort;
    des_pkg::sbox_idx_t               sbox_sel;
    logic [des_pkg::SBOX_IN_W-1:0]    sbox_in;
    logic [des_pkg::SBOX_OUT_W-1:0]   sbox_out;
    logic                             out_valid;
    logic                             out_ready;
    logic [des_pkg::ROUND_OUT_W-1:0]  data_out;
    logic                             busy;

    // Round datapath side: requester, consumer and the shared S-box bank.
    modport master (
        output in_valid, data_in, abort, out_ready, sbox_out,
        input  in_ready, out_valid, data_out, busy, sbox_sel, sbox_in
    );

    // Sequencer side.
    modport slave (
        input  in_valid, data_in, abort, out_ready, sbox_out,
        output in_ready, out_valid, data_out, busy, sbox_sel, sbox_in
    );

endinterface

// File: rtl/sbox_bank.sv
// rtl/sbox_bank.sv - combinational DES S1..S8 lookup selected by sbox_sel
module sbox_bank
    import des_pkg::*;
(
    input  sbox_idx_t               sbox_sel,
    input  logic [SBOX_IN_W-1:0]    sbox_in,
    output logic [SBOX_OUT_W-1:0]   sbox_out
);

    // Each table holds 64 nibbles in row-major order (row*16 + column), entry 0 in the top nibble.
    localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    logic [255:0] tbl;
    logic [5:0]   entry;
    logic [7:0]   bit_pos;

    // Outer bits pick the row, inner four bits pick the column; entry 0 sits at bit 252.
    assign entry   = {sbox_in[5], sbox_in[0], sbox_in[4:1]};
    assign bit_pos = {~entry, 2'b00};

    // Select the table of the S-box currently being served.
    always_comb begin
        tbl = S1;
        case (sbox_sel)
            3'd0:    tbl = S1;
            3'd1:    tbl = S2;
            3'd2:    tbl = S3;
            3'd3:    tbl = S4;
            3'd4:    tbl = S5;
            3'd5:    tbl = S6;
            3'd6:    tbl = S7;
            default: tbl = S8;
        endcase
    end

    assign sbox_out = tbl[bit_pos +: 4];

endmodule

// File: rtl/sbox_sequencer.sv
// rtl/sbox_sequencer.sv - walks one shared S-box bank across the eight slices of a DES round
module sbox_sequencer
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    sbox_sequencer_if.slave   bus
);

    seq_state_t                state_q;
    sbox_idx_t                 idx_q;
    sbox_idx_t                 idx_d;
    logic [ROUND_IN_W-1:0]     word_q;
    logic [ROUND_OUT_W-1:0]    data_out_q;
    logic                      out_valid_q;
    logic                      in_ready_q;
    logic                      busy_q;
    sbox_idx_t                 sel_q;
    logic [SBOX_IN_W-1:0]      sin_q;

    assign idx_d = idx_q + sbox_idx_t'(1);

    // Sequencer FSM: the bank address for slice idx is registered one edge ahead so it is valid throughout its lookup cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            word_q      <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            sel_q       <= '0;
            sin_q       <= '0;
        end else if (bus.abort) begin
            // Abort wins over everything; partially written result nibbles are left as they are.
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            sel_q       <= '0;
            sin_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        word_q     <= bus.data_in;
                        idx_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        sel_q      <= '0;
                        sin_q      <= get_chunk(bus.data_in, '0);
                    end
                end
                RUN: begin
                    data_out_q <= set_nibble(data_out_q, idx_q, bus.sbox_out);
                    if (idx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        sel_q       <= '0;
                        sin_q       <= '0;
                    end else begin
                        idx_q <= idx_d;
                        sel_q <= idx_d;
                        sin_q <= get_chunk(word_q, idx_d);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        idx_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    sel_q       <= '0;
                    sin_q       <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.busy      = busy_q;
    assign bus.sbox_sel  = sel_q;
    assign bus.sbox_in   = sin_q;

endmodule
